// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_BYTES  = 4;
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        ISSUE      = 2'd0,
        WAIT       = 2'd1,
        FLUSH_WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries for decode.
// Flush empties it in one cycle and wins over a simultaneous push or pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_en;
    logic             pop_en;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop_en    = pop && !empty;
    assign push_en   = push && (!full || pop_en);
    assign head_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; validity is tracked by count, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, {pc, instr} buffer, redirect flush.
// Define FETCH_PERF_EN to add saturating fetch/flush performance counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic [ADDR_W-1:0] pc_nxt,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e         state;
    fetch_state_e         state_nxt;
    logic [ADDR_W-1:0]    inflight_pc;
    logic                 handshake;
    logic                 push_fire;
    logic                 pop_fire;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [ENTRY_W-1:0]   head_entry;

    assign imem_req_valid = !rst && (state == ISSUE) && !redir_valid
                            && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_cur;
    assign handshake      = imem_req_valid && imem_req_ready;

    // A response that coincides with a redirect belongs to the old path and is dropped.
    assign push_fire = (state == WAIT) && imem_rsp_valid && !redir_valid && !fifo_full;
    assign pop_fire  = if_valid && if_ready;
    assign if_valid  = !fifo_empty;
    assign if_pc     = head_entry[ENTRY_W-1:DATA_W];
    assign if_instr  = head_entry[DATA_W-1:0];

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        pc_nxt = pc_cur;
        if (redir_valid) begin
            pc_nxt = redir_target & ~ADDR_W'(INSTR_BYTES - 1);
        end else if (handshake) begin
            pc_nxt = pc_cur + ADDR_W'(INSTR_BYTES);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ISSUE: begin
                if (handshake) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid)   state_nxt = ISSUE;
                else if (redir_valid) state_nxt = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                if (imem_rsp_valid) state_nxt = ISSUE;
            end
            default: state_nxt = ISSUE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ISSUE;
            inflight_pc <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) inflight_pc <= pc_cur;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_fire),
        .push_data ({inflight_pc, imem_rsp_data}),
        .pop       (pop_fire),
        .flush     (redir_valid),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push_fire && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (redir_valid && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
    // Counters are compiled out; the fetch datapath is unaffected.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random phase
// against a transaction-level model (pending request + queue of {pc, instr}).
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_cur;
    logic [31:0] pc_nxt;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    // The PC register the fetch unit drives.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_cur <= '0;
        else     pc_cur <= pc_nxt;
    end

    instr_fetch_unit #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_cur         (pc_cur),
        .pc_nxt         (pc_nxt),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    fetch_entry_t mq[$];
    logic         pend_valid = 1'b0;
    logic         pend_stale = 1'b0;
    logic [31:0]  pend_pc = '0;
    int           m_pushes = 0;
    int           m_redirs = 0;

    // Memory responder state
    logic         mem_busy = 1'b0;
    int           mem_wait = 0;
    logic [31:0]  mem_addr = '0;
    int           mem_lat = 1;
    bit           rand_lat = 1'b0;

    // Last sampled values and consumed PCs
    logic         s_req_valid;
    logic [31:0]  s_req_addr;
    logic [31:0]  s_pc_nxt;
    logic [31:0]  s_pc_cur;
    logic         s_if_valid;
    logic [31:0]  popped[$];

    function automatic logic [31:0] data_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance model after posedge.
    task automatic step(input logic rdv, input logic [31:0] rdt, input logic rq_rdy, input logic ifr);
        logic        exp_req;
        logic [31:0] exp_nxt;
        logic        rsp;
        logic        popd;
        logic        dut_hs;
        logic [31:0] dut_addr;
        logic [31:0] cur;
        @(negedge clk);
        redir_valid    = rdv;
        redir_target   = rdt;
        imem_req_ready = rq_rdy;
        if_ready       = ifr;
        imem_rsp_valid = mem_busy && (mem_wait == 0);
        imem_rsp_data  = imem_rsp_valid ? data_of(mem_addr) : $urandom();
        #1;
        cur     = pc_cur;
        exp_req = !pend_valid && !rdv && (mq.size() < DEPTH);
        if (rdv)                    exp_nxt = {rdt[31:2], 2'b00};
        else if (exp_req && rq_rdy) exp_nxt = cur + 32'd4;
        else                        exp_nxt = cur;
        check("req_valid", imem_req_valid, exp_req);
        if (exp_req) check("req_addr", imem_req_addr, cur);
        check("pc_nxt", pc_nxt, exp_nxt);
        check("if_valid", if_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("if_pc", if_pc, mq[0].pc);
            check("if_instr", if_instr, mq[0].instr);
        end
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_pc_nxt    = pc_nxt;
        s_pc_cur    = cur;
        s_if_valid  = if_valid;
        if (if_valid && ifr) popped.push_back(if_pc);
        rsp      = imem_rsp_valid;
        popd     = ifr && (mq.size() != 0);
        dut_hs   = imem_req_valid && rq_rdy;
        dut_addr = imem_req_addr;
        @(posedge clk);
        if (rdv) begin
            m_redirs++;
            mq.delete();
        end else begin
            if (popd) void'(mq.pop_front());
            if (rsp && pend_valid && !pend_stale) begin
                mq.push_back('{pc: pend_pc, instr: data_of(pend_pc)});
                m_pushes++;
            end
        end
        if (rsp)                    pend_valid = 1'b0;
        else if (rdv && pend_valid) pend_stale = 1'b1;
        if (exp_req && rq_rdy) begin
            pend_valid = 1'b1;
            pend_stale = 1'b0;
            pend_pc    = cur;
        end
        if (rsp) mem_busy = 1'b0;
        if (dut_hs) begin
            mem_busy = 1'b1;
            mem_wait = (rand_lat ? int'($urandom_range(1, 3)) : mem_lat) - 1;
            mem_addr = dut_addr;
        end else if (mem_busy && !rsp) begin
            mem_wait--;
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic do_reset();
        #2;
        rst            = 1'b1;
        redir_valid    = 1'b0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_req_valid", imem_req_valid, 1'b0);
        mq.delete();
        pend_valid = 1'b0;
        pend_stale = 1'b0;
        mem_busy   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
        int budget = 30;
        popped.delete();
        while (popped.size() == 0 && budget > 0) begin
            step(1'b0, '0, 1'b1, 1'b1);
            budget--;
        end
        check({tag, "_seen"}, popped.size() != 0, 1'b1);
        if (popped.size() != 0) check(tag, popped[0], exp_pc);
    endtask

    initial begin
        // Reset, then reset again while a request is outstanding with one entry buffered.
        do_reset();
        mem_lat = 1;
        step(1'b0, '0, 1'b1, 1'b0);
        check("first_addr", s_req_addr, 32'h0);
        check("first_pc_nxt", s_pc_nxt, 32'h4);
        step(1'b0, '0, 1'b1, 1'b0);
        mem_lat = 3;
        step(1'b0, '0, 1'b1, 1'b0);
        do_reset();

        // Streaming with 1-cycle memory.
        mem_lat = 1;
        popped.delete();
        repeat (12) step(1'b0, '0, 1'b1, 1'b1);
        check("stream_cnt_ge4", popped.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < popped.size()) check("stream_pc", popped[i], 32'(i * 4));
        end

        // Backpressure: buffer fills, fetch stalls, then drains.
        do_reset();
        mem_lat = 1;
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
        check("bp_req_valid", s_req_valid, 1'b0);
        check("bp_pc_cur", s_pc_cur, 32'h8);
        check("bp_pc_nxt", s_pc_nxt, 32'h8);
        popped.delete();
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        check("bp_resume_valid", s_req_valid, 1'b1);
        check("bp_resume_addr", s_req_addr, 32'h8);
        check("bp_pop_cnt", popped.size(), 2);
        if (popped.size() == 2) begin
            check("bp_pop0", popped[0], 32'h0);
            check("bp_pop1", popped[1], 32'h4);
        end

        // Redirect while a request is outstanding.
        do_reset();
        mem_lat = 3;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h103, 1'b1, 1'b1);
        check("redir_pc_nxt", s_pc_nxt, 32'h100);
        step(1'b0, '0, 1'b1, 1'b1);
        check("redir_empty", s_if_valid, 1'b0);
        wait_pop("redir_first_pc", 32'h100);

        // Redirect, response and pop in the same cycle.
        do_reset();
        mem_lat = 1;
        step(1'b1, 32'h100, 1'b1, 1'b0);
        check("issue_redir_suppress", s_req_valid, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        check("simul_had_entry", s_if_valid, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        check("simul_empty", s_if_valid, 1'b0);
        check("simul_req_valid", s_req_valid, 1'b1);
        check("simul_req_addr", s_req_addr, 32'h100);

        // Stalled memory, then address wrap.
        do_reset();
        mem_lat = 2;
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("wrap_target", s_pc_nxt, 32'hFFFF_FFFC);
        repeat (3) begin
            step(1'b0, '0, 1'b0, 1'b1);
            check("stall_addr", s_req_addr, 32'hFFFF_FFFC);
            check("stall_pc_nxt", s_pc_nxt, 32'hFFFF_FFFC);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        check("wrap_pc_nxt", s_pc_nxt, 32'h0);
        wait_pop("wrap_first_pc", 32'hFFFF_FFFC);

        // Random traffic against the model.
        do_reset();
        rand_lat = 1'b1;
        repeat (3000) begin
            step($urandom_range(0, 19) == 0, $urandom(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end

`ifdef FETCH_PERF_EN
        // Counters were last cleared by the reset before the random phase.
        check("perf_fetch_cnt", perf_fetch_cnt, 32'(m_pushes));
        check("perf_flush_cnt", {16'h0, perf_flush_cnt}, 32'(m_redirs));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        m_pushes = 0;
        m_redirs = 0;
    end

    // Model counters restart with each reset so they track the DUT's counters.
    always @(posedge rst) begin
        m_pushes = 0;
        m_redirs = 0;
    end

endmodule
